// File: rtl/alu_md_pkg.sv
// Shared op-code constants and controller state encoding for the alu_md unit.
package alu_md_pkg;

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SLL   = 4'd1;
   localparam logic [3:0] OP_SLT   = 4'd2;
   localparam logic [3:0] OP_SLTU  = 4'd3;
   localparam logic [3:0] OP_XOR   = 4'd4;
   localparam logic [3:0] OP_SRL   = 4'd5;
   localparam logic [3:0] OP_OR    = 4'd6;
   localparam logic [3:0] OP_AND   = 4'd7;
   localparam logic [3:0] OP_MUL   = 4'd8;
   localparam logic [3:0] OP_MULH  = 4'd9;
   localparam logic [3:0] OP_MULHU = 4'd10;
   localparam logic [3:0] OP_DIV   = 4'd11;
   localparam logic [3:0] OP_DIVU  = 4'd12;
   localparam logic [3:0] OP_REM   = 4'd13;
   localparam logic [3:0] OP_REMU  = 4'd14;
   localparam logic [3:0] OP_ZERO  = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/alu_md_iter.sv
// Iterative multiply / divide datapath, one bit per clock.
// The first iteration is folded into the start edge, working on the freshly
// computed operand magnitudes, so the final iteration lands on the edge where
// count == WIDTH-1 and the controller can enter DONE on that same edge.
// Multiply: shift-add on magnitudes into a {hi, lo} product register.
// Divide: restoring division on magnitudes, quotient shifted into lo,
// partial remainder kept in hi.  Signs are applied to the final step output.
module md_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic             run,
   input  logic             abort,
   input  logic             is_div,
   input  logic             op_signed,
   input  logic             sel_alt,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] res
);

   localparam int CW = $clog2(WIDTH);

   logic [CW-1:0]      count;
   logic [WIDTH-1:0]   x_q, hi_q, lo_q;
   logic               div_q, alt_q, negq_q, negr_q;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH-1:0]   cur_x, cur_hi, cur_lo;
   logic               cur_div;
   logic [WIDTH-1:0]   hi_n, lo_n;
   logic [WIDTH:0]     msum, rsh, dif;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo, rem;

   assign a_neg = op_signed & a[WIDTH-1];
   assign b_neg = op_signed & b[WIDTH-1];
   assign mag_a = a_neg ? -a : a;
   assign mag_b = b_neg ? -b : b;

   // On the start edge the step works on new operands instead of the registers.
   assign cur_x   = start ? (is_div ? mag_b : mag_a) : x_q;
   assign cur_lo  = start ? (is_div ? mag_a : mag_b) : lo_q;
   assign cur_hi  = start ? '0 : hi_q;
   assign cur_div = start ? is_div : div_q;

   assign done = run && (count == CW'(WIDTH - 1));

   // Iteration counter: 1 after the start edge, wraps to 0 on the final edge.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of process ordering.
      if (!rstn || abort) begin
         count <= '0;
      end else if (start) begin
         count <= CW'(1);
      end else if (run) begin
         count <= count + 1'b1;
      end
   end

   // Datapath registers: loaded on start, advanced every running cycle.
   always_ff @(posedge clk) begin
      // NOTE: no reset here on purpose; these registers are always reloaded
      // by start before anything reads them, so a reset would only add fanout.
      if (start) begin
         x_q    <= cur_x;
         div_q  <= is_div;
         alt_q  <= sel_alt;
         negq_q <= is_div ? ((a_neg ^ b_neg) && (b != '0)) : (a_neg ^ b_neg);
         negr_q <= is_div & a_neg;
      end
      if (start || run) begin
         hi_q <= hi_n;
         lo_q <= lo_n;
      end
   end

   // One multiply or divide step.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      hi_n = cur_hi;
      lo_n = cur_lo;
      msum = {1'b0, cur_hi} + (cur_lo[0] ? {1'b0, cur_x} : '0);
      rsh  = {cur_hi, cur_lo[WIDTH-1]};
      dif  = rsh - {1'b0, cur_x};
      if (cur_div) begin
         // dif[WIDTH] is the borrow: set when the divisor does not fit.
         if (!dif[WIDTH]) begin
            hi_n = dif[WIDTH-1:0];
            lo_n = {cur_lo[WIDTH-2:0], 1'b1};
         end else begin
            hi_n = rsh[WIDTH-1:0];
            lo_n = {cur_lo[WIDTH-2:0], 1'b0};
         end
      end else begin
         hi_n = msum[WIDTH:1];
         lo_n = {msum[0], cur_lo[WIDTH-1:1]};
      end
   end

   // Sign fix-up and half/quotient/remainder selection on the final step output.
   always_comb begin
      prod = {hi_n, lo_n};
      if (negq_q) begin
         prod = -prod;
      end
      quo = negq_q ? -lo_n : lo_n;
      rem = negr_q ? -hi_n : hi_n;
      if (div_q) begin
         res = alt_q ? rem : quo;
      end else begin
         res = alt_q ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/alu_md.sv
// ALU with iterative multiply/divide behind a valid/ready handshake.
// Single-cycle ops complete on the accept edge; MUL/DIV ops run WIDTH
// iterations in md_iter.  Result and flags are registered and held in DONE
// until the consumer takes them.
module alu_md
   import alu_md_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic             sp_sign,
   input  logic             uors,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [2:0]       flags
);

   state_t           state, state_n;
   logic             accept, is_md_op, op_is_div, op_signed, op_alt;
   logic             md_start, md_run, md_done;
   logic [WIDTH-1:0] alu_res, md_res;
   logic [2:0]       cmp_flags, flags_pend;
   logic [SHW-1:0]   shamt;
   logic             lt, eq, gt;

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);
   assign accept    = in_valid && in_ready && !flush;
   assign is_md_op  = op[3] && (op != OP_ZERO);
   assign op_is_div = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
   assign op_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   assign op_alt    = (op == OP_MULH) || (op == OP_MULHU) || (op == OP_REM) || (op == OP_REMU);
   assign md_start  = accept && is_md_op;
   assign md_run    = ((state == ST_MUL) || (state == ST_DIV)) && !flush;
   assign shamt     = b[SHW-1:0];

   md_iter #(.WIDTH(WIDTH)) u_md_iter (
      .clk       (clk),
      .rstn      (rstn),
      .start     (md_start),
      .run       (md_run),
      .abort     (flush),
      .is_div    (op_is_div),
      .op_signed (op_signed),
      .sel_alt   (op_alt),
      .a         (a),
      .b         (b),
      .done      (md_done),
      .res       (md_res)
   );

   // Comparison flags {a<b, a==b, a>b}, signed or unsigned per uors.
   always_comb begin
      eq = (a == b);
      if (uors) begin
         lt = (a < b);
         gt = (a > b);
      end else begin
         lt = ($signed(a) < $signed(b));
         gt = ($signed(a) > $signed(b));
      end
      cmp_flags = {lt, eq, gt};
   end

   // Single-cycle operations.
   always_comb begin
      alu_res = '0;
      case (op)
         OP_ADD:  alu_res = sp_sign ? (a - b) : (a + b);
         OP_SLL:  alu_res = a << shamt;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_XOR:  alu_res = a ^ b;
         OP_SRL:  alu_res = sp_sign ? $unsigned($signed(a) >>> shamt) : (a >> shamt);
         OP_OR:   alu_res = a | b;
         OP_AND:  alu_res = a & b;
         default: alu_res = '0;
      endcase
   end

   // Next-state logic; flush returns to IDLE from anywhere.
   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (!is_md_op) begin
                  state_n = ST_DONE;
               end else if (op_is_div) begin
                  state_n = ST_DIV;
               end else begin
                  state_n = ST_MUL;
               end
            end
         end
         ST_MUL, ST_DIV: begin
            if (md_done) begin
               state_n = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_n = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
      if (flush) begin
         state_n = ST_IDLE;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Result/flags registers: loaded on single-cycle accept or on MUL/DIV
   // completion; flags of a MUL/DIV op wait in flags_pend until the result.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         result     <= '0;
         flags      <= '0;
         flags_pend <= '0;
      end else if (!flush) begin
         if (accept) begin
            flags_pend <= cmp_flags;
            if (!is_md_op) begin
               result <= alu_res;
               flags  <= cmp_flags;
            end
         end else if (md_done) begin
            result <= md_res;
            flags  <= flags_pend;
         end
      end
   end

endmodule

// File: tb/tb_alu_md.sv
// Scoreboard bench for alu_md (WIDTH = 32): the driver pushes hand-computed
// expectations, a monitor compares whenever out_valid is presented.
module tb_alu_md;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rstn, flush, in_valid, in_ready, sp_sign, uors;
   logic          out_valid, out_ready;
   logic [3:0]    op;
   logic [W-1:0]  a, b, result;
   logic [2:0]    flags;

   typedef struct {
      logic [31:0] res;
      logic [2:0]  flg;
      int          lat;
      int          acc;
      int          id;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   n_issued = 0;
   bit   seen = 1'b0;

   alu_md #(.WIDTH(W)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .sp_sign   (sp_sign),
      .uors      (uors),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Present one operation and record its expected response.
   task automatic issue(input logic [3:0] o, input logic s, input logic u,
                        input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] er, input logic [2:0] ef);
      exp_t e;
      int   waits;
      waits = 0;
      @(negedge clk);
      while (!in_ready && waits < 100) begin
         @(negedge clk);
         waits++;
      end
      if (!in_ready) begin
         check("in_ready_timeout", 32'd0, 32'd1);
         return;
      end
      op = o; sp_sign = s; uors = u; a = av; b = bv;
      in_valid = 1'b1;
      e.res = er;
      e.flg = ef;
      e.lat = (o >= 4'd8 && o <= 4'd14) ? W : 1;
      e.acc = cyc + 1;
      e.id  = n_issued;
      n_issued++;
      sbq.push_back(e);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Monitor: first valid cycle checks value and latency, later cycles check hold.
   always @(negedge clk) begin
      exp_t cur;
      if (!rstn) begin
         seen = 1'b0;
      end else if (out_valid) begin
         if (sbq.size() == 0) begin
            check("spurious_out_valid", 32'(out_valid), 32'd0);
         end else begin
            cur = sbq[0];
            if (!seen) begin
               check($sformatf("result#%0d", cur.id), result, cur.res);
               check($sformatf("flags#%0d", cur.id), 32'(flags), 32'(cur.flg));
               check($sformatf("latency#%0d", cur.id), 32'(cyc - cur.acc + 1), 32'(cur.lat));
               seen = 1'b1;
            end else begin
               check($sformatf("held_result#%0d", cur.id), result, cur.res);
               check($sformatf("held_flags#%0d", cur.id), 32'(flags), 32'(cur.flg));
            end
            if (out_ready) begin
               cur = sbq.pop_front();
               seen = 1'b0;
            end
         end
      end
   end

   task automatic drain();
      int waits;
      waits = 0;
      while (sbq.size() != 0 && waits < 200) begin
         @(negedge clk);
         waits++;
      end
      check("drain_queue_empty", 32'(sbq.size()), 32'd0);
   endtask

   initial begin
      int waits;
      rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      op = 4'd0; sp_sign = 1'b0; uors = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_result", result, 32'd0);
      check("rst_flags", 32'(flags), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      rstn = 1'b1;

      // op, sp_sign, uors, a, b, expected result, expected flags
      issue(4'd0,  1'b0, 1'b0, 32'd7,        32'd5,        32'd12,       3'b001);
      issue(4'd0,  1'b1, 1'b0, 32'd7,        32'd5,        32'd2,        3'b001);
      issue(4'd5,  1'b1, 1'b0, 32'h80000000, 32'h24,       32'hF8000000, 3'b100);
      issue(4'd5,  1'b0, 1'b1, 32'h80000000, 32'h24,       32'h08000000, 3'b001);
      issue(4'd1,  1'b0, 1'b0, 32'd1,        32'h21,       32'd2,        3'b100);
      issue(4'd2,  1'b0, 1'b1, 32'hFFFFFFFF, 32'd1,        32'd1,        3'b001);
      issue(4'd3,  1'b0, 1'b1, 32'hFFFFFFFF, 32'd1,        32'd0,        3'b001);
      issue(4'd4,  1'b0, 1'b1, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 3'b001);
      issue(4'd6,  1'b0, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 3'b100);
      issue(4'd7,  1'b0, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 3'b100);
      issue(4'd15, 1'b0, 1'b0, 32'd5,        32'd5,        32'd0,        3'b010);
      issue(4'd8,  1'b0, 1'b1, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 3'b001);
      issue(4'd9,  1'b0, 1'b0, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 3'b100);
      issue(4'd10, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd2,        32'h00000001, 3'b001);
      issue(4'd8,  1'b0, 1'b0, 32'd12345,    32'd678,      32'h007FB6F6, 3'b001);
      issue(4'd8,  1'b0, 1'b0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 3'b100);
      issue(4'd9,  1'b0, 1'b0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 3'b100);
      issue(4'd11, 1'b0, 1'b0, 32'd100,      32'd0,        32'hFFFFFFFF, 3'b001);
      issue(4'd13, 1'b0, 1'b0, 32'd100,      32'd0,        32'd100,      3'b001);
      issue(4'd11, 1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 3'b100);
      issue(4'd13, 1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        3'b100);
      issue(4'd11, 1'b0, 1'b0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 3'b100);
      issue(4'd13, 1'b0, 1'b0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 3'b100);
      issue(4'd12, 1'b0, 1'b1, 32'd100,      32'd7,        32'd14,       3'b001);
      issue(4'd14, 1'b0, 1'b1, 32'd100,      32'd7,        32'd2,        3'b001);
      issue(4'd12, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 3'b001);
      issue(4'd14, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 3'b001);
      drain();

      // Consumer stalls for 10 cycles in DONE.
      out_ready = 1'b0;
      issue(4'd0, 1'b0, 1'b0, 32'h10, 32'h20, 32'h30, 3'b100);
      waits = 0;
      while (!out_valid && waits < 10) begin
         @(negedge clk);
         waits++;
      end
      check("hold_out_valid_seen", 32'(out_valid), 32'd1);
      repeat (10) @(negedge clk);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1 out_ready = 1'b1;
      drain();

      // Flush with in_valid in IDLE: no accept.
      @(negedge clk);
      op = 4'd0; a = 32'd1; b = 32'd1; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0; flush = 1'b0;
      check("flush_idle_in_ready", 32'(in_ready), 32'd1);
      check("flush_idle_out_valid", 32'(out_valid), 32'd0);

      // Flush on cycle 5 of a DIV: no result, previous result/flags kept.
      @(negedge clk);
      op = 4'd11; sp_sign = 1'b0; uors = 1'b0; a = 32'd100; b = 32'd7; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      check("div_busy_in_ready", 32'(in_ready), 32'd0);
      repeat (5) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      check("flush_in_ready", 32'(in_ready), 32'd1);
      check("flush_out_valid", 32'(out_valid), 32'd0);
      check("flush_result_kept", result, 32'h30);
      check("flush_flags_kept", 32'(flags), 32'(3'b100));
      repeat (40) @(negedge clk);
      check("flush_no_late_valid", 32'(out_valid), 32'd0);

      // Reset during MUL cycle 10.
      @(negedge clk);
      op = 4'd8; a = 32'd3; b = 32'd3; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (10) @(negedge clk);
      rstn = 1'b0;
      @(posedge clk);
      #1;
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_result", result, 32'd0);
      check("mid_rst_flags", 32'(flags), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      rstn = 1'b1;
      repeat (40) @(negedge clk);
      check("post_rst_no_valid", 32'(out_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_md.md
ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (≥8, power of two).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rstn  input  1  synchronous active-low reset.
REQ-006 flush  input  1  synchronous abort of the operation in flight.
REQ-007 in_valid  input  1  operand/op offer.
REQ-008 in_ready  output  1  unit can accept an operation.
REQ-009 op  input  4  operation code.
REQ-010 sp_sign  input  1  ADD: subtract; SRL: arithmetic shift.
REQ-011 uors  input  1  flags: 1 = unsigned compare, 0 = signed compare.
REQ-012 a, b  input  WIDTH  operands.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  consumer takes result.
REQ-015 result  output  WIDTH  registered result.
REQ-016 flags  output  3  registered {a<b, a==b, a>b} per uors.

Function
REQ-017 Op codes: 0 ADD/SUB, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL/SRA, 6 OR, 7 AND, 8 MUL, 9 MULH, 10 MULHU, 11 DIV, 12 DIVU, 13 REM, 14 REMU; 15 yields result 0.
REQ-018 States: IDLE, MUL, DIV, DONE; in_ready = 1 only in IDLE.
REQ-019 Accept on edge where in_valid && in_ready; operands, op, sp_sign and uors captured at that edge.
REQ-020 Ops 0-7 and 15: IDLE→DONE on accept edge; out_valid high the following cycle (latency 1).
REQ-021 Shifts use b[SHW-1:0] only; ADD/SUB wrap modulo 2^WIDTH; SLT/SLTU produce 0 or 1 zero-extended.
REQ-022 Ops 8-10: IDLE→MUL; shift-add, one bit per cycle; 2·WIDTH-bit product; MUL returns low half, MULH signed×signed high half, MULHU unsigned high half.
REQ-023 Ops 11-14: IDLE→DIV; restoring division on magnitudes, one bit per cycle, sign fix-up at final iteration; quotient sign = sign(a)^sign(b), remainder sign = sign(a).
REQ-024 MUL/DIV: iteration counter 0..WIDTH-1; the edge completing iteration WIDTH-1 enters DONE; out_valid rises exactly WIDTH cycles after accept.
REQ-025 Divide by zero: DIV/DIVU = all ones, REM/REMU = a; no extra cycles.
REQ-026 Signed overflow (a = 100..0, b = all ones): DIV = a, REM = 0.
REQ-027 flags computed from captured a, b for every op; valid with result.
REQ-028 DONE: result/flags held stable while out_ready = 0; DONE→IDLE on out_valid && out_ready.
REQ-029 No back-to-back accept in the edge that retires a result; in_ready rises the cycle after.
REQ-030 flush = 1: next state IDLE, out_valid = 0, result and flags unchanged, no accept that edge even if in_valid = 1.
REQ-031 flush in IDLE is a no-op; flush in DONE discards the pending result.

Reset
REQ-032 rstn = 0 at an edge: state IDLE, counter 0, result 0, flags 0, out_valid 0, in_ready 1 after edge; overrides flush and any in-flight MUL/DIV.
REQ-033 Internal accumulator/quotient/remainder registers need no reset value; they are not observable until reloaded.

Structure
REQ-034 Package alu_md_pkg SHALL hold op-code constants and the state enum.
REQ-035 Iterative multiply/divide datapath SHALL be sub-module md_iter (start, is_div, signed controls, count, done); single-cycle ops stay in alu_md.

Verification (WIDTH = 32)
REQ-036 ADD a=7, b=5, sp_sign=0 → result 12, out_valid one cycle after accept; sp_sign=1 → 2; flags (uors=0) = 3'b001.
REQ-037 SRL a=0x80000000, b=0x24 (shift 4): sp_sign=1 → 0xF8000000; sp_sign=0 → 0x08000000.
REQ-038 a=0xFFFFFFFF, b=2: MUL → 0xFFFFFFFE, MULH → 0xFFFFFFFF, MULHU → 0x00000001; out_valid exactly 32 cycles after accept.
REQ-039 DIV a=100, b=0 → 0xFFFFFFFF, REM → 100; DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000, REM → 0; DIV a=-7, b=2 → -3, REM → -1.
REQ-040 out_ready=0 for 10 cycles in DONE → result stable, in_ready 0; flush on cycle 5 of a DIV → out_valid never rises, in_ready 1 next cycle.
REQ-041 rstn=0 during MUL cycle 10 → next cycle out_valid 0, result 0, in_ready 1.
